// File: rtl/acc_result_writer_pkg.sv
// ============================================================================
// Module : acc_result_writer_pkg
// Brief  : Shared types and widths for the accelerator result writer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package acc_result_writer_pkg;

    localparam int REG_AW = 5;   // register-file address width
    localparam int POS_W  = 4;   // pos tag width
    localparam int CNT_W  = 3;   // packet word-count width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Register address of word idx of a packet starting at base; wraps mod 32.
    function automatic logic [REG_AW-1:0] wrap_addr(
        input logic [REG_AW-1:0] base,
        input logic [CNT_W-1:0]  idx
    );
        return base + {{(REG_AW-CNT_W){1'b0}}, idx};
    endfunction

endpackage

`default_nettype wire

// File: rtl/acc_range_check.sv
// ============================================================================
// Module : acc_range_check
// Brief  : Combinational test whether addr lies in base+first .. base+count-1
//          (register addresses wrap modulo 32).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module acc_range_check
    import acc_result_writer_pkg::*;
(
    input  logic [REG_AW-1:0] addr_i,
    input  logic [REG_AW-1:0] base_i,
    input  logic [CNT_W-1:0]  first_i,
    input  logic [CNT_W-1:0]  count_i,
    output logic              hit_o
);

    logic [REG_AW-1:0] w_offset;

    // Distance from the packet base, taken modulo 32 so wrapped ranges work.
    assign w_offset = addr_i - base_i;

    assign hit_o = ({{(REG_AW-CNT_W){1'b0}}, first_i} <= w_offset) &&
                   (w_offset < {{(REG_AW-CNT_W){1'b0}}, count_i});

endmodule

`default_nettype wire

// File: rtl/acc_result_writer.sv
// ============================================================================
// Module : acc_result_writer
// Brief  : Writes accelerator result packets into the register file one word
//          per cycle, yielding to CPU writeback. Optional hazard detection is
//          enabled by defining ACC_HAZARD_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module acc_result_writer
    import acc_result_writer_pkg::*;
#(
    parameter int WORDS = 4,
    parameter int DW    = 32
) (
    input  logic                   clk_i,
    input  logic                   reset,
    input  logic                   cpu_we_i,
    input  logic [4:0]             cpu_addr_i,
    input  logic [DW-1:0]          cpu_data_i,
    input  logic [3:0]             cpu_pos_i,
    input  logic                   res_valid_i,
    output logic                   res_ready_o,
    input  logic [4:0]             res_addr_i,
    input  logic [2:0]             res_count_i,
    input  logic [WORDS*DW-1:0]    res_data_i,
    input  logic [WORDS*4-1:0]     res_pos_i,
    input  logic [4:0]             chk_rs_i,
    input  logic [4:0]             chk_rt_i,
    output logic                   RegWrite_o,
    output logic [4:0]             RDaddr_o,
    output logic [DW-1:0]          RDdata_o,
    output logic [3:0]             is_pos_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   hazard_o
);

    localparam logic [CNT_W-1:0] WORDS_C = CNT_W'(WORDS);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        k_q, k_d;
    logic [REG_AW-1:0]       base_q, base_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [WORDS*DW-1:0]     data_q, data_d;
    logic [WORDS*POS_W-1:0]  pos_q, pos_d;

    logic [CNT_W-1:0]        w_count_clamped;
    logic [DW-1:0]           w_word;
    logic [POS_W-1:0]        w_pos;
    logic                    w_rs_hit;
    logic                    w_rt_hit;

    assign w_count_clamped = (res_count_i > WORDS_C) ? WORDS_C : res_count_i;

    always_comb begin
        w_word = '0;
        w_pos  = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (k_q == CNT_W'(i)) begin
                w_word = data_q[DW*i +: DW];
                w_pos  = pos_q[POS_W*i +: POS_W];
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            base_q  <= '0;
            count_q <= '0;
            data_q  <= '0;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            base_q  <= base_d;
            count_q <= count_d;
            data_q  <= data_d;
            pos_q   <= pos_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        base_d      = base_q;
        count_d     = count_q;
        data_d      = data_q;
        pos_d       = pos_q;
        res_ready_o = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        RegWrite_o  = cpu_we_i;
        RDaddr_o    = cpu_addr_i;
        RDdata_o    = cpu_data_i;
        is_pos_o    = cpu_pos_i;

        case (state_q)
            IDLE: begin
                res_ready_o = 1'b1;
                if (res_valid_i) begin
                    base_d  = res_addr_i;
                    count_d = w_count_clamped;
                    data_d  = res_data_i;
                    pos_d   = res_pos_i;
                    k_d     = '0;
                    state_d = (w_count_clamped != '0) ? WRITE : DONE;
                end
            end
            WRITE: begin
                busy_o = 1'b1;
                // CPU writeback owns the port this cycle; the packet simply stalls.
                if (!cpu_we_i) begin
                    RegWrite_o = 1'b1;
                    RDaddr_o   = wrap_addr(base_q, k_q);
                    RDdata_o   = w_word;
                    is_pos_o   = w_pos;
                    if (k_q == count_q - CNT_W'(1)) begin
                        k_d     = '0;
                        state_d = DONE;
                    end else begin
                        k_d = k_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Reset is asynchronous, so the write strobe must drop with it at once.
        if (reset) begin
            RegWrite_o = 1'b0;
        end
    end

    acc_range_check u_rs_check (
        .addr_i  (chk_rs_i),
        .base_i  (base_q),
        .first_i (k_q),
        .count_i (count_q),
        .hit_o   (w_rs_hit)
    );

    acc_range_check u_rt_check (
        .addr_i  (chk_rt_i),
        .base_i  (base_q),
        .first_i (k_q),
        .count_i (count_q),
        .hit_o   (w_rt_hit)
    );

`ifdef ACC_HAZARD_EN
    assign hazard_o = (state_q == WRITE) && (w_rs_hit || w_rt_hit);
`else
    logic w_unused_hits;
    assign w_unused_hits = w_rs_hit ^ w_rt_hit;
    assign hazard_o      = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_acc_result_writer.sv
// ============================================================================
// Module : tb_acc_result_writer
// Brief  : Self-checking bench for acc_result_writer against a queue model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_acc_result_writer;

    localparam int WORDS = 4;
    localparam int DW    = 32;
`ifdef ACC_HAZARD_EN
    localparam logic HZ_EN = 1'b1;
`else
    localparam logic HZ_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                clk_unused_guard;
    logic                reset;
    logic                cpu_we;
    logic [4:0]          cpu_addr;
    logic [DW-1:0]       cpu_data;
    logic [3:0]          cpu_pos;
    logic                res_valid;
    logic                res_ready;
    logic [4:0]          res_addr;
    logic [2:0]          res_count;
    logic [WORDS*DW-1:0] res_data;
    logic [WORDS*4-1:0]  res_pos;
    logic [4:0]          chk_rs, chk_rt;
    logic                RegWrite;
    logic [4:0]          RDaddr;
    logic [DW-1:0]       RDdata;
    logic [3:0]          is_pos;
    logic                busy, done, hazard;

    assign clk_unused_guard = clk;

    acc_result_writer #(.WORDS(WORDS), .DW(DW)) dut (
        .clk_i       (clk),
        .reset       (reset),
        .cpu_we_i    (cpu_we),
        .cpu_addr_i  (cpu_addr),
        .cpu_data_i  (cpu_data),
        .cpu_pos_i   (cpu_pos),
        .res_valid_i (res_valid),
        .res_ready_o (res_ready),
        .res_addr_i  (res_addr),
        .res_count_i (res_count),
        .res_data_i  (res_data),
        .res_pos_i   (res_pos),
        .chk_rs_i    (chk_rs),
        .chk_rt_i    (chk_rt),
        .RegWrite_o  (RegWrite),
        .RDaddr_o    (RDaddr),
        .RDdata_o    (RDdata),
        .is_pos_o    (is_pos),
        .busy_o      (busy),
        .done_o      (done),
        .hazard_o    (hazard)
    );

    // {ready, regwrite, addr, data, pos, busy, done, hazard}
    logic [45:0] w_dut;
    assign w_dut = {res_ready, RegWrite, RDaddr, RDdata, is_pos, busy, done, hazard};

    // Reference model: the words still owed to the register file, in order.
    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  pos;
    } wr_t;

    wr_t q[$];
    bit  m_done;
    int  tests = 0;
    int  fails = 0;

    logic        a_regw, a_busy, a_done;
    logic [4:0]  a_addr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [45:0] model_out();
        logic       m_busy;
        logic       m_ready;
        logic       hz;
        logic       regw;
        logic [4:0] addr;
        logic [31:0] data;
        logic [3:0] pos;
        m_busy  = !m_done && (q.size() > 0);
        m_ready = !m_done && (q.size() == 0);
        regw    = cpu_we;
        addr    = cpu_addr;
        data    = cpu_data;
        pos     = cpu_pos;
        if (m_busy && !cpu_we) begin
            regw = 1'b1;
            addr = q[0].addr;
            data = q[0].data;
            pos  = q[0].pos;
        end
        hz = 1'b0;
        if (HZ_EN && m_busy) begin
            foreach (q[i]) begin
                if (q[i].addr == chk_rs || q[i].addr == chk_rt) hz = 1'b1;
            end
        end
        return {m_ready, regw, addr, data, pos, m_busy, m_done, hz};
    endfunction

    task automatic model_update();
        int  n;
        wr_t w;
        if (m_done) begin
            m_done = 1'b0;
        end else if (q.size() > 0) begin
            if (!cpu_we) begin
                void'(q.pop_front());
                if (q.size() == 0) m_done = 1'b1;
            end
        end else if (res_valid) begin
            n = (res_count > 3'd4) ? 4 : int'(res_count);
            for (int i = 0; i < n; i++) begin
                w.addr = 5'((int'(res_addr) + i) % 32);
                w.data = res_data[32*i +: 32];
                w.pos  = res_pos[4*i +: 4];
                q.push_back(w);
            end
            if (n == 0) m_done = 1'b1;
        end
    endtask

    // Called just after a rising edge: compare at the falling edge, advance model.
    task automatic step(input string name);
        logic [45:0] exp;
        @(negedge clk);
        exp = model_out();
        check(name, 64'(w_dut), 64'(exp));
        a_regw = RegWrite;
        a_busy = busy;
        a_done = done;
        a_addr = RDaddr;
        @(posedge clk);
        model_update();
        #1;
    endtask

    typedef struct {
        logic [4:0]   base;
        logic [2:0]   cnt;
        logic [127:0] data;
        logic [15:0]  cpu_mask;
        int           exp_nw;
        int           exp_done;
        logic [4:0]   exp_first;
        logic [4:0]   exp_last;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int nw, dc;
        logic [4:0] first, last;

        tbl[0] = '{5'd4,  3'd2, {64'h0, 32'h11111111, 32'h07530320}, 16'h0000, 2, 3, 5'd4,  5'd5};
        tbl[1] = '{5'd7,  3'd3, {32'hA3, 32'hA2, 32'hA1, 32'hA0},    16'h0004, 3, 5, 5'd7,  5'd9};
        tbl[2] = '{5'd30, 3'd4, {32'hB3, 32'hB2, 32'hB1, 32'hB0},    16'h0000, 4, 5, 5'd30, 5'd1};
        tbl[3] = '{5'd10, 3'd0, {32'hC3, 32'hC2, 32'hC1, 32'hC0},    16'h0000, 0, 1, 5'd0,  5'd0};
        tbl[4] = '{5'd2,  3'd7, {32'hD3, 32'hD2, 32'hD1, 32'hD0},    16'h0000, 4, 5, 5'd2,  5'd5};
        tbl[5] = '{5'd31, 3'd1, {32'hE3, 32'hE2, 32'hE1, 32'hE0},    16'h000E, 1, 5, 5'd31, 5'd31};

        reset = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_data = '0; cpu_pos = '0;
        res_valid = 1'b0; res_addr = '0; res_count = '0; res_data = '0; res_pos = '0;
        chk_rs = '0; chk_rt = '0;
        m_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 64'({RegWrite, busy, done, hazard}), 64'(0));
        reset = 1'b0;
        #1;
        check("reset_ready", 64'(res_ready), 64'(1));
        step("idle");

        for (int v = 0; v < 6; v++) begin
            res_valid = 1'b1; res_addr = tbl[v].base; res_count = tbl[v].cnt;
            res_data = tbl[v].data; res_pos = 16'($urandom); cpu_we = 1'b0;
            step("vec_accept");
            // Scramble packet inputs: the captured buffer must not follow them.
            res_valid = 1'b0; res_addr = 5'($urandom); res_count = 3'($urandom);
            res_data = {$urandom, $urandom, $urandom, $urandom}; res_pos = 16'($urandom);
            nw = 0; dc = -1; first = '0; last = '0;
            for (int j = 1; j <= 8; j++) begin
                cpu_we = tbl[v].cpu_mask[j]; cpu_addr = 5'd9; cpu_data = 32'hDEADBEEF; cpu_pos = 4'h5;
                step("vec_cycle");
                if (a_regw && a_busy && !cpu_we) begin
                    if (nw == 0) first = a_addr;
                    last = a_addr;
                    nw++;
                end
                if (a_done && dc < 0) dc = j;
            end
            cpu_we = 1'b0;
            check("vec_nwrites", 64'(nw), 64'(tbl[v].exp_nw));
            check("vec_done_cycle", 64'(dc), 64'(tbl[v].exp_done));
            if (tbl[v].exp_nw > 0) begin
                check("vec_first_addr", 64'(first), 64'(tbl[v].exp_first));
                check("vec_last_addr", 64'(last), 64'(tbl[v].exp_last));
            end
        end

        // Hazard window: base 12, count 4; after two writes 14..15 are pending.
        res_valid = 1'b1; res_addr = 5'd12; res_count = 3'd4; res_data = {4{$urandom}};
        chk_rs = 5'd0; chk_rt = 5'd0;
        step("hz_accept");
        res_valid = 1'b0;
        step("hz_w0");
        step("hz_w1");
        chk_rs = 5'd13; chk_rt = 5'd13;
        #1;
        check("hz_rs13", 64'(hazard), 64'(0));
        chk_rt = 5'd15;
        #1;
        check("hz_rt15", 64'(hazard), 64'(HZ_EN));
        step("hz_w2");
        repeat (3) step("hz_tail");
        chk_rs = '0; chk_rt = '0;

        // Reset in the middle of a 4-word packet.
        res_valid = 1'b1; res_addr = 5'd20; res_count = 3'd4; res_data = {4{$urandom}};
        step("rst_accept");
        res_valid = 1'b0; chk_rs = 5'd22;
        step("rst_first_write");
        cpu_we = 1'b1; cpu_addr = 5'd3; cpu_data = 32'h12345678;
        reset = 1'b1;
        #1;
        check("rst_mid_outputs", 64'({RegWrite, busy, done, hazard}), 64'(0));
        cpu_we = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        m_done = 1'b0;
        for (int j = 0; j < 6; j++) step("rst_after");

        for (int c = 0; c < 400; c++) begin
            res_valid = ($urandom % 3) != 0;
            res_addr  = 5'($urandom);
            res_count = 3'($urandom);
            res_data  = {$urandom, $urandom, $urandom, $urandom};
            res_pos   = 16'($urandom);
            cpu_we    = ($urandom % 4) == 0;
            cpu_addr  = 5'($urandom);
            cpu_data  = $urandom;
            cpu_pos   = 4'($urandom);
            chk_rs    = (q.size() > 0 && ($urandom % 2) == 1) ? q[$urandom % q.size()].addr : 5'($urandom);
            chk_rt    = 5'($urandom);
            step("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
